// File: rtl/recorder_pkg.sv
// Shared types and constants for the recorder address/timing engine.
// Mode decode is a pure function of the registered control strobes.
package recorder_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam logic [3:0] NO_KEY = 4'b1111;

    typedef enum logic [2:0] {
        MODE_CLEAR,
        MODE_REC,
        MODE_REW,
        MODE_PLAY,
        MODE_HOLD_FWD,
        MODE_IDLE
    } mode_e;

    // clea outranks everything; able/direc/twice_play select the rest
    function automatic mode_e decode_mode(input logic able, input logic direc,
                                          input logic clea, input logic twice_play);
        if (clea)
            return MODE_CLEAR;
        if (able) begin
            if (direc)
                return MODE_PLAY;
            return twice_play ? MODE_REW : MODE_REC;
        end
        return direc ? MODE_HOLD_FWD : MODE_IDLE;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..DIV-1 and pulses tick for one cycle at DIV-1.
// clr holds the count at 0, so the first tick lands DIV cycles after clr drops.
module sample_tick_gen
    import recorder_pkg::*;
#(
    parameter int DIV = 6250
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/rec_play_addr_seq.sv
// Record/play address and timing engine behind the recorder control FSM.
// Optional elapsed-seconds counter on pos_sec is enabled by defining POS_SECONDS_EN.
module rec_play_addr_seq
    import recorder_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DIV           = 6250,
    parameter int TICKS_PER_SEC = 8000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              able,
    input  logic              direc,
    input  logic              clea,
    input  logic              twice_play,
    output logic              finish,
    output logic              mem_full,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W:0]   rec_len,
    output logic [7:0]        pos_sec
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_W;

    if (DIV < 2 || TICKS_PER_SEC < 1) begin : g_param_check
        $error("rec_play_addr_seq: DIV must be >= 2 and TICKS_PER_SEC >= 1");
    end

    mode_e             mode;
    logic              tick;
    logic [PW-1:0]     wr_ptr, wr_n, rd_ptr, rd_n, step, sum;
    logic [ADDR_W-1:0] addr_n;
    logic              fin_n, we_n, re_n;

    assign mode = decode_mode(able, direc, clea, twice_play);

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (!able || clea),
        .tick (tick)
    );

    always_comb begin
        wr_n   = wr_ptr;
        rd_n   = rd_ptr;
        addr_n = mem_addr;
        fin_n  = finish;
        we_n   = 1'b0;
        re_n   = 1'b0;
        step   = twice_play ? PW'(2) : PW'(1);
        sum    = rd_ptr + step;
        case (mode)
            MODE_CLEAR: begin
                wr_n  = '0;
                rd_n  = '0;
                fin_n = 1'b0;
            end
            MODE_REC: begin
                if (tick && wr_ptr < DEPTH) begin
                    we_n   = 1'b1;
                    addr_n = wr_ptr[ADDR_W-1:0];
                    wr_n   = wr_ptr + PW'(1);
                end
            end
            MODE_REW: begin
                fin_n = finish || (rd_ptr == '0);
                // step back first, then read the sample we landed on
                if (tick && rd_ptr != '0) begin
                    rd_n   = (rd_ptr > PW'(1)) ? rd_ptr - PW'(2) : '0;
                    re_n   = 1'b1;
                    addr_n = rd_n[ADDR_W-1:0];
                end
            end
            MODE_PLAY: begin
                fin_n = finish || (rd_ptr >= wr_ptr);
                if (tick && rd_ptr < wr_ptr) begin
                    re_n   = 1'b1;
                    addr_n = rd_ptr[ADDR_W-1:0];
                    rd_n   = (sum > wr_ptr) ? wr_ptr : sum;
                end
            end
            MODE_HOLD_FWD: begin
                fin_n = 1'b0;
            end
            MODE_IDLE: begin
                rd_n  = '0;
                fin_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_addr <= '0;
            finish   <= 1'b0;
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
        end else begin
            wr_ptr   <= wr_n;
            rd_ptr   <= rd_n;
            mem_addr <= addr_n;
            finish   <= fin_n;
            mem_we   <= we_n;
            mem_re   <= re_n;
        end
    end

    assign rec_len  = wr_ptr;
    assign mem_full = (wr_ptr == DEPTH);

`ifdef POS_SECONDS_EN
    localparam int SW = $clog2(TICKS_PER_SEC + 2);

    logic [SW-1:0] sub_cnt, sub_n, sub_sum;
    logic [7:0]    sec_q, sec_n;

    always_comb begin
        sub_n   = sub_cnt;
        sec_n   = sec_q;
        sub_sum = sub_cnt + (twice_play ? SW'(2) : SW'(1));
        if (mode == MODE_CLEAR || mode == MODE_IDLE) begin
            sub_n = '0;
            sec_n = '0;
        end else if (tick && (mode == MODE_REC || mode == MODE_PLAY || mode == MODE_REW)) begin
            if (sub_sum >= SW'(TICKS_PER_SEC)) begin
                sub_n = sub_sum - SW'(TICKS_PER_SEC);
                if (mode == MODE_REW)
                    sec_n = (sec_q == 8'd0) ? 8'd0 : sec_q - 8'd1;
                else
                    sec_n = (sec_q == 8'd255) ? 8'd255 : sec_q + 8'd1;
            end else begin
                sub_n = sub_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt <= '0;
            sec_q   <= '0;
        end else begin
            sub_cnt <= sub_n;
            sec_q   <= sec_n;
        end
    end

    assign pos_sec = sec_q;
`else
    assign pos_sec = '0;
`endif

endmodule

// File: tb/tb_rec_play_addr_seq.sv
// Directed table-driven bench for rec_play_addr_seq (ADDR_W=3, DIV=4).
// Each row applies one input mode for a fixed number of cycles and checks the strobes seen.
module tb_rec_play_addr_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       able = 1'b0, direc = 1'b0, clea = 1'b0, twice_play = 1'b0;
    logic       finish, mem_full, mem_we, mem_re;
    logic [2:0] mem_addr;
    logic [3:0] rec_len;
    logic [7:0] pos_sec;

    rec_play_addr_seq #(.ADDR_W(3), .DIV(4), .TICKS_PER_SEC(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .able       (able),
        .direc      (direc),
        .clea       (clea),
        .twice_play (twice_play),
        .finish     (finish),
        .mem_full   (mem_full),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .rec_len    (rec_len),
        .pos_sec    (pos_sec)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        able, direc, clea, twice, early_fin;
        logic [7:0]  cycles;
        logic [3:0]  n_we, n_re;
        logic [31:0] addrs;   // expected strobe addresses, first in [3:0]
        logic        fin, full;
        logic [3:0]  len;
    } vec_t;

    vec_t tbl[17];
    int   n_checks = 0;
    int   n_err = 0;

    // strobe log
    int         cyc = 0;
    int         ev_n = 0;
    int         ev_cyc[256];
    logic [2:0] ev_addr[256];
    logic       ev_re[256];
    int         both_cnt = 0, wide_cnt = 0;
    logic       prev_we = 1'b0, prev_re = 1'b0;
    int         row_start_cyc, row_start_ev;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we && mem_re)
                both_cnt <= both_cnt + 1;
            if ((mem_we && prev_we) || (mem_re && prev_re))
                wide_cnt <= wide_cnt + 1;
            if ((mem_we || mem_re) && ev_n < 256) begin
                ev_addr[ev_n] <= mem_addr;
                ev_re[ev_n]   <= mem_re;
                ev_cyc[ev_n]  <= cyc;
                ev_n          <= ev_n + 1;
            end
        end
        prev_we <= mem_we;
        prev_re <= mem_re;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a, input logic d, input logic c, input logic t,
                                input logic e, input int cy, input int nwe, input int nre,
                                input logic [31:0] ad, input logic f, input logic fl,
                                input int ln);
        vec_t v;
        v.able = a; v.direc = d; v.clea = c; v.twice = t; v.early_fin = e;
        v.cycles = 8'(cy); v.n_we = 4'(nwe); v.n_re = 4'(nre);
        v.addrs = ad; v.fin = f; v.full = fl; v.len = 4'(ln);
        return v;
    endfunction

    task automatic run_row(input int idx);
        vec_t v;
        int   s, nwe, nre, k;
        v = tbl[idx];
        able = v.able; direc = v.direc; clea = v.clea; twice_play = v.twice;
        s = ev_n;
        row_start_ev  = s;
        row_start_cyc = cyc;
        for (int c = 0; c < int'(v.cycles); c++) begin
            @(negedge clk); #1;
            if (c == 0 && v.early_fin)
                check($sformatf("row%0d finish_after_first_cycle", idx), int'(finish), 1);
        end
        nwe = 0; nre = 0; k = 0;
        for (int i = s; i < ev_n; i++) begin
            if (ev_re[i]) nre++; else nwe++;
            if (k < 8)
                check($sformatf("row%0d strobe%0d_addr", idx, k), int'(ev_addr[i]),
                      int'(v.addrs[4*k +: 3]));
            k++;
        end
        check($sformatf("row%0d we_count", idx), nwe, int'(v.n_we));
        check($sformatf("row%0d re_count", idx), nre, int'(v.n_re));
        check($sformatf("row%0d finish", idx), int'(finish), int'(v.fin));
        check($sformatf("row%0d mem_full", idx), int'(mem_full), int'(v.full));
        check($sformatf("row%0d rec_len", idx), int'(rec_len), int'(v.len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        //             able dir clea twc early cyc we re addrs         fin full len
        tbl[0]  = mk(1, 0, 0, 0, 0, 22, 5, 0, 32'h0004_3210, 0, 0, 5); // record 5
        tbl[1]  = mk(0, 0, 0, 0, 0,  3, 0, 0, 32'h0,         0, 0, 5); // idle
        tbl[2]  = mk(1, 1, 0, 0, 0, 30, 0, 5, 32'h0004_3210, 1, 0, 5); // play x1
        tbl[3]  = mk(0, 1, 0, 0, 0,  3, 0, 0, 32'h0,         0, 0, 5); // hold drops finish
        tbl[4]  = mk(0, 0, 0, 0, 0,  2, 0, 0, 32'h0,         0, 0, 5);
        tbl[5]  = mk(1, 1, 0, 1, 0, 20, 0, 3, 32'h0000_0420, 1, 0, 5); // play x2
        tbl[6]  = mk(0, 0, 0, 0, 0,  2, 0, 0, 32'h0,         0, 0, 5);
        tbl[7]  = mk(1, 1, 0, 0, 0, 12, 0, 3, 32'h0000_0210, 0, 0, 5); // play to rd=3
        tbl[8]  = mk(1, 0, 0, 1, 0, 16, 0, 2, 32'h0000_0001, 1, 0, 5); // rewind
        tbl[9]  = mk(0, 0, 0, 0, 0,  2, 0, 0, 32'h0,         0, 0, 5);
        tbl[10] = mk(1, 1, 0, 0, 0,  8, 0, 2, 32'h0000_0010, 0, 0, 5); // restarts at 0
        tbl[11] = mk(1, 1, 1, 0, 0,  1, 0, 0, 32'h0,         0, 0, 0); // clear mid-play
        tbl[12] = mk(1, 1, 0, 0, 1,  6, 0, 0, 32'h0,         1, 0, 0); // play empty
        tbl[13] = mk(0, 0, 0, 0, 0,  2, 0, 0, 32'h0,         0, 0, 0);
        tbl[14] = mk(1, 0, 0, 0, 0, 44, 8, 0, 32'h7654_3210, 0, 1, 8); // fill memory
        tbl[15] = mk(1, 0, 1, 0, 0,  1, 0, 0, 32'h0,         0, 0, 0);
        tbl[16] = mk(1, 0, 0, 0, 0,  8, 2, 0, 32'h0000_0010, 0, 0, 2); // ends on a write

        repeat (3) @(negedge clk);
        #1;
        check("reset finish", int'(finish), 0);
        check("reset mem_full", int'(mem_full), 0);
        check("reset mem_we", int'(mem_we), 0);
        check("reset mem_re", int'(mem_re), 0);
        check("reset mem_addr", int'(mem_addr), 0);
        check("reset rec_len", int'(rec_len), 0);
        check("reset pos_sec", int'(pos_sec), 0);
        rst = 1'b0;

        run_row(0);
        check("rec first_we_cycle", ev_cyc[row_start_ev] - row_start_cyc, 4);
        check("rec fifth_we_cycle", ev_cyc[row_start_ev + 4] - row_start_cyc, 20);

        for (int i = 1; i < 17; i++)
            run_row(i);

        // asynchronous reset while a write strobe is high
        check("pre_rst mem_we", int'(mem_we), 1);
        rst = 1'b1;
        #1;
        check("async_rst mem_we", int'(mem_we), 0);
        check("async_rst mem_re", int'(mem_re), 0);
        check("async_rst mem_addr", int'(mem_addr), 0);
        check("async_rst rec_len", int'(rec_len), 0);
        check("async_rst finish", int'(finish), 0);
        check("async_rst mem_full", int'(mem_full), 0);
        check("async_rst pos_sec", int'(pos_sec), 0);
        able = 1'b0; direc = 1'b0; clea = 1'b0; twice_play = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;

        check("we_and_re_overlap", both_cnt, 0);
        check("strobe_wider_than_one", wide_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
